// File: rtl/lp_fp_pkg.sv
// Shared FP32 field constants, operand classes and pack helper for the approximate multiply datapath.
// Pure declarations: no latency, no flow control.
package lp_fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 127;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_e;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  function automatic logic [31:0] fp32_pack(input logic s, input logic [7:0] e, input logic [22:0] f);
    return {s, e, f};
  endfunction

endpackage

// File: rtl/lp_fp_classify.sv
// Operand classifier (ZERO with denormals flushed, NORM, INF, NAN).
// Purely combinational, zero latency, no flow control.
module lp_fp_classify
  import lp_fp_pkg::*;
#(
  parameter int EXP_WIDTH = FP_EXP_W
) (
  input  logic [EXP_WIDTH-1:0] exp_field,
  input  logic                 nz,
  output logic [1:0]           cls
);

  always_comb begin
    cls = CLS_NORM;
    if (exp_field == '0) begin
      cls = CLS_ZERO;
    end else if (&exp_field) begin
      cls = nz ? CLS_NAN : CLS_INF;
    end
  end

endmodule

// File: rtl/lp_fp_normalize_pack.sv
// Exponent normalize, special-case resolve and pack of the approximate FP32 product; 2-cycle latency.
// Valid/ready pipeline, 1 txn/cycle; in_ready is combinational from out_ready, output held while stalled.
module lp_fp_normalize_pack
  import lp_fp_pkg::*;
#(
  parameter int EXP_WIDTH = FP_EXP_W,
  parameter int MAN_WIDTH = FP_MAN_W,
  parameter int BIAS      = FP_BIAS,
  parameter int CNT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           sign_a,
  input  logic                           sign_b,
  input  logic [EXP_WIDTH-1:0]           exp_a,
  input  logic [EXP_WIDTH-1:0]           exp_b,
  input  logic                           man_a_nz,
  input  logic                           man_b_nz,
  input  logic [MAN_WIDTH-1:0]           lp_mantissa,
  input  logic [1:0]                     lp_shift,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [EXP_WIDTH+MAN_WIDTH:0]   out_result,
  output logic [CNT_WIDTH-1:0]           ovf_cnt,
  output logic [CNT_WIDTH-1:0]           unf_cnt,
  output logic                           lt1_seen,
  input  logic                           cnt_clr
);

  localparam int EW = EXP_WIDTH + 2;
  localparam int RW = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_WIDTH) - 1);
  localparam logic [RW-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};

  logic s1_valid, s2_valid, s1_en, s2_en, accept, fire;
  logic [1:0] cls_a, cls_b;
  logic [EW-1:0] e_in;

  logic                  s1_sign;
  logic [1:0]            s1_cls_a, s1_cls_b;
  logic signed [EW-1:0]  s1_e;
  logic [MAN_WIDTH-1:0]  s1_man;

  logic [RW-1:0] res;
  logic          res_ovf, res_unf, s2_ovf, s2_unf;
  logic          any_nan, any_inf, any_zero;

  assign s2_en     = !s2_valid || out_ready;
  assign s1_en     = !s1_valid || s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_valid;
  assign accept    = in_valid && in_ready;
  assign fire      = s2_valid && out_ready;

  lp_fp_classify #(.EXP_WIDTH(EXP_WIDTH)) u_cls_a (.exp_field(exp_a), .nz(man_a_nz), .cls(cls_a));
  lp_fp_classify #(.EXP_WIDTH(EXP_WIDTH)) u_cls_b (.exp_field(exp_b), .nz(man_b_nz), .cls(cls_b));

  // Two guard bits keep the sum exact; modular arithmetic yields the two's-complement value.
  assign e_in = EW'(exp_a) + EW'(exp_b) - EW'(BIAS) + EW'(lp_shift[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_sign  <= sign_a ^ sign_b;
      s1_cls_a <= cls_a;
      s1_cls_b <= cls_b;
      s1_e     <= $signed(e_in);
      s1_man   <= lp_mantissa;
    end
  end

  always_comb begin
    any_nan  = (s1_cls_a == CLS_NAN)  || (s1_cls_b == CLS_NAN);
    any_inf  = (s1_cls_a == CLS_INF)  || (s1_cls_b == CLS_INF);
    any_zero = (s1_cls_a == CLS_ZERO) || (s1_cls_b == CLS_ZERO);
    res      = {s1_sign, s1_e[EXP_WIDTH-1:0], s1_man};
    res_ovf  = 1'b0;
    res_unf  = 1'b0;
    if (any_nan || (any_inf && any_zero)) begin
      res = QNAN;
    end else if (any_inf) begin
      res = {s1_sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
    end else if (any_zero) begin
      res = {s1_sign, {(RW-1){1'b0}}};
    end else if (s1_e >= E_MAX) begin
      res     = {s1_sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
      res_ovf = 1'b1;
    end else if (s1_e[EW-1] || (s1_e == '0)) begin
      res     = {s1_sign, {(RW-1){1'b0}}};
      res_unf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s2_en && s1_valid) begin
      s2_ovf <= res_ovf;
      s2_unf <= res_unf;
    end
  end

  // Clear beats increment and the sticky set in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt  <= '0;
      unf_cnt  <= '0;
      lt1_seen <= 1'b0;
    end else if (cnt_clr) begin
      ovf_cnt  <= '0;
      unf_cnt  <= '0;
      lt1_seen <= 1'b0;
    end else begin
      if (fire && s2_ovf && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + 1'b1;
      if (fire && s2_unf && (unf_cnt != '1)) unf_cnt <= unf_cnt + 1'b1;
      if (accept && (lp_shift == 2'b00)) lt1_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lp_fp_normalize_pack.sv
// Directed, table-driven bench for lp_fp_normalize_pack with hand sequences for stall and reset corners.
module tb_lp_fp_normalize_pack;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, sign_a, sign_b, man_a_nz, man_b_nz;
  logic [7:0]  exp_a, exp_b;
  logic [22:0] lp_mantissa;
  logic [1:0]  lp_shift;
  logic        out_valid, out_ready, lt1_seen, cnt_clr;
  logic [31:0] out_result;
  logic [15:0] ovf_cnt, unf_cnt;

  int passed = 0;
  int total  = 0;
  int last_lat;

  localparam logic [31:0] QN = 32'h7FC00000;

  always #5 clk = ~clk;

  lp_fp_normalize_pack dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sign_a(sign_a), .sign_b(sign_b), .exp_a(exp_a), .exp_b(exp_b),
    .man_a_nz(man_a_nz), .man_b_nz(man_b_nz), .lp_mantissa(lp_mantissa),
    .lp_shift(lp_shift), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt),
    .lt1_seen(lt1_seen), .cnt_clr(cnt_clr)
  );

  typedef struct {
    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic        nza, nzb;
    logic [1:0]  sh;
    logic [22:0] man;
    logic [31:0] ex;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic sa, logic sb, logic [7:0] ea, logic [7:0] eb, logic nza, logic nzb,
                              logic [1:0] sh, logic [22:0] man, logic [31:0] ex);
    vec_t v;
    v.sa = sa; v.sb = sb; v.ea = ea; v.eb = eb; v.nza = nza; v.nzb = nzb;
    v.sh = sh; v.man = man; v.ex = ex;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    sign_a = v.sa; sign_b = v.sb; exp_a = v.ea; exp_b = v.eb;
    man_a_nz = v.nza; man_b_nz = v.nzb; lp_shift = v.sh; lp_mantissa = v.man;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Send one transaction with out_ready high, check result and acceptance-to-valid latency.
  task automatic run_one(input vec_t v, input string name);
    int n;
    drive(v);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    last_lat = n;
    if (!out_valid) chk({name, "_timeout"}, 0, 1);
    else            chk(name, out_result, v.ex);
    step();
  endtask

  initial begin
    logic [31:0] got[3];
    int ngot, stale;
    logic acc;

    tbl[0]  = mk(0, 0, 127, 127, 1, 1, 2'b10, 23'h100000, 32'h40100000);
    tbl[1]  = mk(0, 0, 254, 254, 1, 1, 2'b01, 23'h0,      32'h7F800000);
    tbl[2]  = mk(1, 0,   1,   1, 1, 1, 2'b01, 23'h0,      32'h80000000);
    tbl[3]  = mk(0, 0, 255, 127, 1, 0, 2'b01, 23'h0,      QN);
    tbl[4]  = mk(0, 0, 255,   0, 0, 0, 2'b01, 23'h0,      QN);
    tbl[5]  = mk(0, 1, 255, 130, 0, 0, 2'b01, 23'h0,      32'hFF800000);
    tbl[6]  = mk(1, 0,   0, 200, 0, 1, 2'b01, 23'h12345,  32'h80000000);
    tbl[7]  = mk(0, 0, 127, 127, 1, 1, 2'b00, 23'h400000, 32'h3FC00000);
    tbl[8]  = mk(0, 0, 200, 181, 1, 1, 2'b01, 23'h7FFFFF, 32'h7F7FFFFF);
    tbl[9]  = mk(0, 0, 200, 182, 1, 1, 2'b01, 23'h7FFFFF, 32'h7F800000);
    tbl[10] = mk(0, 0,  64,  64, 1, 1, 2'b01, 23'h000123, 32'h00800123);
    tbl[11] = mk(0, 0,  63,  64, 1, 1, 2'b01, 23'h000123, 32'h00000000);
    tbl[12] = mk(1, 1, 100, 100, 1, 1, 2'b11, 23'h2AAAAA, 32'h252AAAAA);
    tbl[13] = mk(1, 0,   0, 255, 0, 1, 2'b01, 23'h0,      QN);
    tbl[14] = mk(1, 0, 255, 255, 0, 0, 2'b01, 23'h0,      32'hFF800000);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    drive(tbl[0]);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_ovf", ovf_cnt, 0);
    chk("rst_unf", unf_cnt, 0);
    chk("rst_lt1", lt1_seen, 0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 15; i++) begin
      run_one(tbl[i], $sformatf("vec%0d", i));
      chk($sformatf("lat%0d", i), last_lat, 1);
    end
    chk("ovf_cnt_table", ovf_cnt, 2);
    chk("unf_cnt_table", unf_cnt, 2);
    chk("lt1_after_00", lt1_seen, 1);

    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_ovf", ovf_cnt, 0);
    chk("clr_unf", unf_cnt, 0);
    chk("clr_lt1", lt1_seen, 0);

    // Clear in the same cycle as a 2'b00 acceptance keeps lt1_seen low.
    drive(tbl[7]);
    in_valid = 1'b1; cnt_clr = 1'b1;
    step();
    in_valid = 1'b0; cnt_clr = 1'b0;
    chk("clr_beats_lt1", lt1_seen, 0);
    step();
    chk("clr_vec_result", out_result, tbl[7].ex);
    step();

    // Backpressure: three back-to-back inputs with out_ready low.
    out_ready = 1'b0;
    drive(tbl[0]); in_valid = 1'b1;
    step();
    drive(tbl[8]);
    chk("bp_rdy_after1", in_ready, 1);
    step();
    drive(tbl[12]);
    chk("bp_rdy_after2", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_head", out_result, tbl[0].ex);
    repeat (3) step();
    chk("bp_hold_rdy", in_ready, 0);
    chk("bp_hold_result", out_result, tbl[0].ex);
    chk("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    ngot = 0;
    for (int c = 0; c < 20 && ngot < 3; c++) begin
      if (out_valid) begin got[ngot] = out_result; ngot++; end
      acc = in_valid && in_ready;
      step();
      if (acc) in_valid = 1'b0;
    end
    chk("bp_count", ngot, 3);
    chk("bp_order0", got[0], tbl[0].ex);
    chk("bp_order1", got[1], tbl[8].ex);
    chk("bp_order2", got[2], tbl[12].ex);
    in_valid = 1'b0;
    step();

    // Reset with two transactions in flight.
    run_one(tbl[1], "pre_rst_ovf_vec");
    run_one(tbl[7], "pre_rst_lt1_vec");
    chk("pre_rst_ovf", ovf_cnt, 1);
    out_ready = 1'b0;
    drive(tbl[0]); in_valid = 1'b1;
    step();
    drive(tbl[8]);
    step();
    in_valid = 1'b0;
    chk("inflight_rdy", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_result", out_result, 0);
    chk("mid_rst_ovf", ovf_cnt, 0);
    chk("mid_rst_lt1", lt1_seen, 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("post_rst_rdy", in_ready, 1);
    stale = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid) stale++;
      step();
    end
    chk("post_rst_stale", stale, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lp_fp_normalize_pack.md
# lp_fp_normalize_pack

Downstream consumer of the approximate log-piecewise mantissa multiplier in the approximate FP32 multiply datapath. Per transaction it takes the approximate mantissa product and its 2-bit range/shift code, together with the operand signs, exponents and mantissa-nonzero flags from the unpack stage. It then normalizes the exponent, resolves IEEE-754 special cases, and packs a single-precision result. It is a 2-stage valid/ready pipeline that also counts overflow and underflow events for error characterisation.

## Interface
- EXP_WIDTH, 8, exponent field width
- MAN_WIDTH, 23, mantissa field width (must match the multiplier WIDTH)
- BIAS, 127, exponent bias
- CNT_WIDTH, 16, event counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low; the only reset in the block
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept input this cycle
- sign_a, sign_b  in  1  operand signs
- exp_a, exp_b  in  EXP_WIDTH  biased operand exponents
- man_a_nz, man_b_nz  in  1  operand mantissa field nonzero
- lp_mantissa  in  MAN_WIDTH  approximate product fraction (multiplier mantissa_out)
- lp_shift  in  2  product integer bits (multiplier shift): 2'b1x means product ≥ 2.0; 2'b01 means [1,2); 2'b00 means approximation < 1.0
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_result  out  1+EXP_WIDTH+MAN_WIDTH  packed {sign, exp, frac}
- ovf_cnt, unf_cnt  out  CNT_WIDTH  saturating event counters
- lt1_seen  out  1  sticky flag: an lp_shift==2'b00 transaction was accepted
- cnt_clr  in  1  synchronous clear of the counters and lt1_seen

## Operation
- Input is accepted when in_valid && in_ready.
- Stage 1 (S1) registers the following:
  - sign = sign_a ^ sign_b.
  - Class of each operand: ZERO (exp==0, denormals flushed), INF (exp==all-ones, !nz), NAN (exp==all-ones, nz), NORM.
  - e = exp_a + exp_b − BIAS + lp_shift[1], computed as a (EXP_WIDTH+2)-bit signed value.
  - lp_mantissa, passed through unchanged.
- Stage 2 (S2) resolves the result in priority order:
  1. Any NAN, or INF×ZERO → canonical qNaN {0, all-ones, 1 followed by 0s} (0x7FC00000 at default parameters).
  2. Any INF → {sign, all-ones, 0}.
  3. Any ZERO → {sign, 0, 0}.
  4. e ≥ 2^EXP_WIDTH−1 → {sign, all-ones, 0}; ovf_cnt increments.
  5. e ≤ 0 → {sign, 0, 0}; unf_cnt increments.
  6. Otherwise → {sign, e[EXP_WIDTH-1:0], lp_mantissa}.
- No rounding is applied; the fraction is used as truncated upstream.
- lp_shift==2'b00 is handled exactly like 2'b01 (no exponent decrement), and sets lt1_seen.
- Counters:
  - A counter increments only when its S2 result transfers (out_valid && out_ready).
  - Counters saturate at all-ones.
  - cnt_clr has priority over an increment in the same cycle.
  - lt1_seen is set when an lp_shift==2'b00 transaction is accepted at the input. If cnt_clr is asserted in that same cycle, cnt_clr wins and lt1_seen stays 0.

## Timing
- Latency: 2 cycles from input acceptance to out_valid, with a full-throughput pipeline of 1 transaction per cycle.
- Handshake:
  - Stage advance: s2_en = !s2_valid || out_ready; s1_en = !s1_valid || s2_en.
  - in_ready = s1_en, a combinational path from out_ready.
  - Results leave in strict input order.
- out_result and out_valid are held stable while out_valid && !out_ready.
- At most 2 transactions are in flight; with out_ready low, in_ready falls after the second acceptance.
- Reset, including mid-operation: s1_valid, s2_valid, out_valid = 0; out_result = 0; ovf_cnt, unf_cnt = 0; lt1_seen = 0. In-flight transactions are discarded.
- Data registers need no reset, except out_result, which is reset to 0.

## Structure
- Shared package lp_fp_pkg holds:
  - FP32 field-width constants and BIAS.
  - The operand class enum (ZERO, NORM, INF, NAN).
  - The qNaN constant.
  - A pack helper function.
- One combinational sub-module, lp_fp_classify, is instantiated once per operand. It takes exp and nz and returns the class.
- The pipeline registers, S2 resolution and counters stay in the top module.

## Test plan
- 1.5×1.5: exp_a=exp_b=127, signs 0, lp_shift=2'b10, lp_mantissa=0x100000 → out_result=0x40100000 two cycles after acceptance.
- Overflow: exp_a=exp_b=254, lp_shift=2'b01, mantissa 0 → 0x7F800000 and ovf_cnt=1. Then underflow: exp_a=exp_b=1, sign_a=1 → 0x80000000 and unf_cnt=1.
- Specials:
  - exp_a=255, man_a_nz=1 → 0x7FC00000.
  - exp_a=255, !man_a_nz with exp_b=0 → 0x7FC00000.
  - exp_a=255, !man_a_nz with sign_b=1, exp_b=130 → 0xFF800000.
- Backpressure: 3 back-to-back inputs with out_ready held low → in_ready drops after 2 acceptances, out_result is held stable, and all 3 results emerge in order once out_ready rises.
- lp_shift=2'b00 with exp_a=exp_b=127 → exponent 127 and lt1_seen=1. Then cnt_clr pulse → lt1_seen=0 and counters 0.
- rst_n asserted while 2 transactions are in flight → out_valid=0 and counters 0 immediately, no stale output after release, and in_ready=1 on the first cycle after release.
